uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
Round-robin arbiter that shares one uart_tx transmitter between NUM_REQ byte producers. It takes bytes through a valid/ack handshake and drives the transmitter's start/data inputs, using its ready output to sequence one byte at a time. An optional per-requester lock keeps ownership across a multi-byte packet so packets are never interleaved on the serial line.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
IDW, 2, width of grant_id; must equal clog2(NUM_REQ)
START_TIMEOUT, 16, cycles to wait for tx_ready to fall after a start pulse before re-issuing start

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
req_valid  input  NUM_REQ  requester i has a byte on its data lane
req_data  input  NUM_REQ*8  byte lanes; requester i at bits [8i+7:8i]
req_lock  input  NUM_REQ  requester i requests ownership beyond the current byte
req_ack  output  NUM_REQ  one-cycle pulse; byte of requester i captured
tx_start  output  1  start pulse to uart_tx
tx_data  output  8  byte to uart_tx, held stable from start until tx_ready rises again
tx_ready  input  1  uart_tx idle/ready
busy  output  1  high whenever state != IDLE
grant_id  output  IDW  index of the current or most recent granted requester

Behaviour:
- Reset (async, immediate): state=IDLE; tx_start=0; tx_data=0; req_ack=0; grant_id=0; busy=0; lock released; RR pointer=NUM_REQ-1, so requester 0 has first priority.
- States: IDLE, ARM, SEND.
- IDLE: arbitrate when tx_ready=1 and any req_valid=1.
  - If locked: grant only the owner and ignore all others. Stay in IDLE while owner valid=0.
  - Otherwise: grant the first valid index scanning from pointer+1 upward, modulo NUM_REQ.
  - At the clock edge: tx_data<=lane, tx_start<=1, req_ack[g]<=1, grant_id<=g, pointer<=g, state<=ARM.
  - Latency: valid sampled high at edge N, start and ack high in cycle N..N+1; exactly one cycle each.
- Requester rule: data must be stable while valid=1 and ack=0. After sampling ack, the requester may change data or drop valid. A valid high in the cycle that ack is high is treated as a new byte.
- ARM: tx_start=0.
  - tx_ready=0 -> SEND.
  - Otherwise count cycles. At START_TIMEOUT, re-pulse tx_start for one cycle with the same tx_data, produce no new ack, and clear the counter.
- SEND: wait for tx_ready=1, then go to IDLE.
  - At that edge, if req_lock[g]=1, set locked owner=g. Otherwise clear the lock.
  - Minimum of one IDLE cycle between bytes.
- Lock release: the owner deasserting req_lock while in IDLE releases the lock at the next edge. Lock from a non-owner is ignored until that requester is granted.
- tx_data stays unchanged from grant until the next grant. Never modify it in ARM or SEND.
- req_valid changes during ARM/SEND have no effect. No ack is produced outside the IDLE->ARM edge.
- tx_ready=0 in IDLE: no grant and no ack, regardless of requests.
- At most one req_ack bit is high in any cycle. tx_start is never high in two consecutive cycles.

Test Plan:
- Single byte: after reset, req_valid[2]=1 with lane2=8'h41, tx_ready=1 -> next cycle tx_start=1, req_ack=4'b0100, tx_data=8'h41, grant_id=2. Model drops ready; on its return, busy=0.
- Fairness: all four valid continuously, lanes 8'h30..8'h33 -> grant order 0,1,2,3,0,1; exactly one ack per byte.
- Lock: req 1 sends 3 bytes with lock=1 while req 0 valid -> bytes 1,1,1 with no interleaving. Req 1 drops lock -> req 0 granted next.
- Start timeout: tx_ready held 1 after start -> tx_start re-pulses after 16 cycles with the same tx_data. Ack count stays 1 and there is no re-pulse once ready falls.
- Reset mid-SEND: assert rst while busy=1 -> tx_start, req_ack and busy are 0 immediately. After release, requester 0 wins a simultaneous 0/3 request.
- tx_ready low in IDLE with req_valid=1 for 20 cycles -> no ack and no start. Ready rises -> grant the following cycle.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin share of one uart_tx among NUM_REQ
// byte producers, with per-requester lock so packets never interleave.
//
// Ports:
//   clk, rst        rising-edge clock, async active-high reset
//   req_valid[i]    requester i presents a byte on lane i
//   req_data        byte lanes, lane i at [8i+7:8i]
//   req_lock[i]     requester i wants to keep ownership after this byte
//   req_ack[i]      one-cycle pulse, byte of requester i captured
//   tx_start        start pulse to uart_tx
//   tx_data         byte to uart_tx, stable from grant to next grant
//   tx_ready        uart_tx idle
//   busy            high while a byte is in flight (state != IDLE)
//   grant_id        current or most recent granted requester
module uart_tx_arbiter #(
  parameter int NUM_REQ       = 4,
  parameter int IDW           = 2,
  parameter int START_TIMEOUT = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [NUM_REQ*8-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_lock,
  output logic [NUM_REQ-1:0]   req_ack,
  output logic                 tx_start,
  output logic [7:0]           tx_data,
  input  logic                 tx_ready,
  output logic                 busy,
  output logic [IDW-1:0]       grant_id
);

  localparam int CW = $clog2(START_TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    SEND
  } state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [IDW-1:0]       ptr_q, ptr_d;
  logic [IDW-1:0]       gid_q, gid_d;
  logic                 lock_q, lock_d;
  logic                 start_q, start_d;
  logic [7:0]           data_q, data_d;
  logic [NUM_REQ-1:0]   ack_q, ack_d;
  logic                 busy_q, busy_d;

  logic [7:0]           lanes [NUM_REQ];
  logic [IDW-1:0]       pick;
  logic                 pick_ok;
  logic [IDW:0]         idx;

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      lanes[i] = req_data[8*i +: 8];
    end
  end

  // While locked only the owner (last grant) may win; otherwise scan
  // upward from the pointer+1, wrapping at NUM_REQ.
  always_comb begin
    pick    = '0;
    pick_ok = 1'b0;
    idx     = '0;
    if (lock_q) begin
      pick    = gid_q;
      pick_ok = req_valid[gid_q];
    end else begin
      for (int i = 1; i <= NUM_REQ; i++) begin
        idx = {1'b0, ptr_q} + (IDW+1)'(i);
        if (idx >= (IDW+1)'(NUM_REQ)) begin
          idx = idx - (IDW+1)'(NUM_REQ);
        end
        if (!pick_ok && req_valid[idx[IDW-1:0]]) begin
          pick_ok = 1'b1;
          pick    = idx[IDW-1:0];
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    gid_d   = gid_q;
    lock_d  = lock_q;
    start_d = 1'b0;
    data_d  = data_q;
    ack_d   = '0;
    unique case (state_q)
      IDLE: begin
        if (lock_q && !req_lock[gid_q]) begin
          lock_d = 1'b0;
        end
        if (tx_ready && pick_ok) begin
          state_d     = ARM;
          start_d     = 1'b1;
          ack_d[pick] = 1'b1;
          data_d      = lanes[pick];
          gid_d       = pick;
          ptr_d       = pick;
          cnt_d       = '0;
        end
      end
      ARM: begin
        // Transmitter missed the pulse if ready never drops: retry.
        if (!tx_ready) begin
          state_d = SEND;
          cnt_d   = '0;
        end else if (cnt_q == CW'(START_TIMEOUT - 1)) begin
          start_d = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      SEND: begin
        if (tx_ready) begin
          state_d = IDLE;
          lock_d  = req_lock[gid_q];
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ptr_q   <= IDW'(NUM_REQ - 1);
      gid_q   <= '0;
      lock_q  <= 1'b0;
      start_q <= 1'b0;
      data_q  <= '0;
      ack_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      gid_q   <= gid_d;
      lock_q  <= lock_d;
      start_q <= start_d;
      data_q  <= data_d;
      ack_q   <= ack_d;
      busy_q  <= busy_d;
    end
  end

  assign req_ack  = ack_q;
  assign tx_start = start_q;
  assign tx_data  = data_q;
  assign busy     = busy_q;
  assign grant_id = gid_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: requester queues and a uart_tx stand-in drive the
// arbiter; a transaction-level model predicts every output each cycle.
module tb_uart_tx_arbiter;
  localparam int N  = 4;
  localparam int TO = 16;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   req_valid = '0;
  logic [N*8-1:0] req_data = '0;
  logic [N-1:0]   req_lock = '0;
  logic [N-1:0]   req_ack;
  logic           tx_start;
  logic [7:0]     tx_data;
  logic           tx_ready = 1'b1;
  logic           busy;
  logic [1:0]     grant_id;

  uart_tx_arbiter #(.NUM_REQ(N), .IDW(2), .START_TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_lock(req_lock), .req_ack(req_ack), .tx_start(tx_start),
    .tx_data(tx_data), .tx_ready(tx_ready), .busy(busy),
    .grant_id(grant_id)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // requester side
  logic [7:0] q [N][$];
  logic [N-1:0] en = '1;
  int grants[$];
  int acked = 0;

  // uart stand-in: 0 normal, 1 ignores starts, 2 held not-ready
  int uart_mode = 0;
  int uart_cnt = 0;
  int uart_lo = 0;
  int uart_hi = 3;

  // model state
  bit         m_active, m_low, m_lock;
  int         m_wait, m_ptr, m_owner;
  logic       e_start, e_busy;
  logic [N-1:0] e_ack;
  logic [7:0] e_data;
  logic [1:0] e_gid;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      if (miscompares <= 40)
        $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_active = 0; m_low = 0; m_lock = 0;
    m_wait = 0; m_ptr = N - 1; m_owner = 0;
    e_start = 0; e_busy = 0; e_ack = '0; e_data = '0; e_gid = '0;
  endtask

  // One clock edge of the arbiter described by its rules.
  task automatic model_step();
    int g, d, bestd;
    bit release_lock;
    e_start = 0;
    e_ack = '0;
    if (rst) begin
      model_reset();
      return;
    end
    if (!m_active) begin
      release_lock = m_lock && !req_lock[m_owner];
      if (tx_ready) begin
        g = -1;
        if (m_lock) begin
          if (req_valid[m_owner]) g = m_owner;
        end else begin
          bestd = N;
          for (int i = 0; i < N; i++) begin
            d = (i - m_ptr - 1 + 2 * N) % N;
            if (req_valid[i] && d < bestd) begin
              bestd = d;
              g = i;
            end
          end
        end
        if (g >= 0) begin
          e_start = 1;
          e_ack[g] = 1'b1;
          e_data = req_data[8*g +: 8];
          e_gid = 2'(g);
          m_owner = g;
          m_ptr = g;
          m_active = 1;
          m_low = 0;
          m_wait = 0;
        end
      end
      if (release_lock) m_lock = 0;
    end else if (!m_low) begin
      if (!tx_ready) m_low = 1;
      else begin
        m_wait++;
        if (m_wait == TO) begin
          e_start = 1;
          m_wait = 0;
        end
      end
    end else if (tx_ready) begin
      m_active = 0;
      m_lock = req_lock[m_owner];
    end
    e_busy = m_active;
  endtask

  function automatic int pending();
    int s = 0;
    for (int i = 0; i < N; i++) s += q[i].size();
    return s;
  endfunction

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      req_valid[i] = en[i] && (q[i].size() > 0);
      req_data[8*i +: 8] = (q[i].size() > 0) ? q[i][0] : 8'h00;
    end
  endtask

  task automatic uart_step();
    case (uart_mode)
      1: tx_ready = 1'b1;
      2: tx_ready = 1'b0;
      default: begin
        if (!tx_ready) begin
          if (uart_cnt > 0) uart_cnt--;
          else tx_ready = 1'b1;
        end else if (tx_start) begin
          tx_ready = 1'b0;
          uart_cnt = $urandom_range(uart_hi, uart_lo);
        end
      end
    endcase
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check("tx_start", tx_start, e_start);
    check("req_ack", req_ack, e_ack);
    check("tx_data", tx_data, e_data);
    check("grant_id", grant_id, e_gid);
    check("busy", busy, e_busy);
    if (req_ack != '0) begin
      grants.push_back(int'(grant_id));
      acked += $countones(req_ack);
    end
    for (int i = 0; i < N; i++)
      if (req_ack[i] && q[i].size() > 0) void'(q[i].pop_front());
    uart_step();
    drive();
  endtask

  task automatic run_until_idle(string name, int budget);
    int n = 0;
    while ((busy || pending() > 0) && n < budget) begin
      tick();
      n++;
    end
    check(name, (n < budget), 1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    for (int i = 0; i < N; i++) q[i].delete();
    en = '1;
    req_lock = '0;
    uart_mode = 0;
    uart_cnt = 0;
    uart_lo = 0;
    uart_hi = 3;
    tx_ready = 1'b1;
    drive();
    tick();
    tick();
    rst = 1'b0;
    grants.delete();
  endtask

  initial begin : main
    int n, s, a, a0, pushed;
    int st[$];
    model_reset();

    // reset state and a single byte
    do_reset();
    check("rst_gid", grant_id, 0);
    check("rst_busy", busy, 0);
    check("rst_start", tx_start, 0);
    q[2].push_back(8'h41);
    drive();
    tick();
    check("s1_start", tx_start, 1);
    check("s1_ack", req_ack, 4'b0100);
    check("s1_data", tx_data, 8'h41);
    check("s1_gid", grant_id, 2);
    run_until_idle("s1_drain", 100);
    check("s1_busy", busy, 0);

    // fairness
    do_reset();
    for (int r = 0; r < 3; r++)
      for (int i = 0; i < N; i++) q[i].push_back(8'(8'h30 + i));
    drive();
    run_until_idle("fair_drain", 600);
    check("fair_count", grants.size(), 12);
    for (int k = 0; k < 6; k++)
      check("fair_order", (k < grants.size()) ? grants[k] : -1, k % 4);

    // lock keeps requester 1 until it drops lock
    do_reset();
    en[0] = 1'b0;
    req_lock[1] = 1'b1;
    q[1].push_back(8'hA0);
    q[1].push_back(8'hA1);
    q[1].push_back(8'hA2);
    q[0].push_back(8'hB0);
    drive();
    n = 0;
    while (grants.size() < 3 && n < 300) begin
      tick();
      if (grants.size() >= 1) en[0] = 1'b1;
      drive();
      n++;
    end
    repeat (20) tick();
    check("lock_hold", grants.size(), 3);
    req_lock[1] = 1'b0;
    n = 0;
    while (grants.size() < 4 && n < 60) begin
      tick();
      n++;
    end
    for (int k = 0; k < 4; k++)
      check("lock_order", (k < grants.size()) ? grants[k] : -1,
            (k < 3) ? 1 : 0);
    run_until_idle("lock_drain", 100);

    // start timeout re-pulse
    do_reset();
    uart_mode = 1;
    q[3].push_back(8'h5A);
    drive();
    a0 = acked;
    st.delete();
    for (int k = 0; k < 40; k++) begin
      tick();
      if (tx_start) st.push_back(k);
    end
    check("to_starts", st.size(), 3);
    check("to_gap1", (st.size() > 1) ? st[1] - st[0] : -1, 16);
    check("to_gap2", (st.size() > 2) ? st[2] - st[1] : -1, 16);
    check("to_data", tx_data, 8'h5A);
    uart_mode = 0;
    tx_ready = 1'b0;
    uart_cnt = 10;
    s = 0;
    for (int k = 0; k < 30; k++) begin
      tick();
      s += int'(tx_start);
    end
    check("to_no_repulse", s, 0);
    check("to_acks", acked - a0, 1);
    check("to_busy", busy, 0);

    // reset while sending
    do_reset();
    uart_lo = 6;
    uart_hi = 6;
    q[0].push_back(8'h77);
    drive();
    n = 0;
    while (!(busy && !tx_ready) && n < 50) begin
      tick();
      n++;
    end
    tick();
    check("mid_busy", busy, 1);
    #2;
    rst = 1'b1;
    #1;
    check("mid_start", tx_start, 0);
    check("mid_ack", req_ack, 0);
    check("mid_busy0", busy, 0);
    model_reset();
    for (int i = 0; i < N; i++) q[i].delete();
    tx_ready = 1'b1;
    uart_cnt = 0;
    uart_lo = 0;
    uart_hi = 3;
    drive();
    tick();
    tick();
    rst = 1'b0;
    grants.delete();
    q[0].push_back(8'hC0);
    q[3].push_back(8'hC3);
    drive();
    run_until_idle("mid_drain", 200);
    check("mid_first", (grants.size() > 0) ? grants[0] : -1, 0);
    check("mid_second", (grants.size() > 1) ? grants[1] : -1, 3);

    // ready low in idle
    do_reset();
    uart_mode = 2;
    tx_ready = 1'b0;
    q[1].push_back(8'h99);
    drive();
    s = 0;
    a = 0;
    repeat (20) begin
      tick();
      s += int'(tx_start);
      a += $countones(req_ack);
    end
    check("rdy_low_start", s, 0);
    check("rdy_low_ack", a, 0);
    uart_mode = 0;
    tx_ready = 1'b1;
    tick();
    check("rdy_up_ack", req_ack, 4'b0010);
    check("rdy_up_start", tx_start, 1);
    check("rdy_up_data", tx_data, 8'h99);
    run_until_idle("rdy_drain", 100);

    // randomized traffic
    do_reset();
    a0 = acked;
    pushed = 0;
    for (int c = 0; c < 4000; c++) begin
      tick();
      if ($urandom_range(7, 0) == 0) begin
        n = $urandom_range(N - 1, 0);
        if (q[n].size() < 6) begin
          q[n].push_back(8'($urandom));
          pushed++;
        end
      end
      for (int i = 0; i < N; i++)
        if ($urandom_range(39, 0) == 0) req_lock[i] = ~req_lock[i];
      if ($urandom_range(299, 0) == 0) uart_mode = (uart_mode == 0) ? 1 : 0;
      drive();
    end
    req_lock = '0;
    uart_mode = 0;
    run_until_idle("rand_drain", 3000);
    check("rand_bytes", acked - a0, pushed);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
